// File: rtl/mcu_bus_pkg.sv
// Shared definitions for the MCU-FPGA 8-bit parallel bus slave.
//  - state_t      : transaction sequencer states
//  - *_BASE/*_ADDR: register map anchors
//  - num_bytes()  : byte registers needed to cover a given pin count
package mcu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LATCH = 2'd1,
    EXEC  = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam logic [7:0] OUT_BASE    = 8'h00;
  localparam logic [7:0] OE_BASE     = 8'h20;
  localparam logic [7:0] IN_BASE     = 8'h40;
  localparam logic [7:0] ID_ADDR     = 8'hF0;
  localparam logic [7:0] STATUS_ADDR = 8'hF1;
  localparam logic [7:0] COMMIT_ADDR = 8'hF2;

  function automatic int num_bytes(input int pins);
    return (pins + 7) / 8;
  endfunction

endpackage

// File: rtl/mcu_bus_sync.sv
// Multi-bit flop synchronizer, DEPTH flops per bit, asynchronous active-high reset.
// Ports:
//  clk  in  1      destination clock
//  rst  in  1      asynchronous reset, clears every stage
//  d    in  WIDTH  asynchronous input
//  q    out WIDTH  synchronized output (last stage)
module mcu_bus_sync #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_reg [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stage_reg[gi] <= '0;
        end else if (gi == 0) begin
          stage_reg[gi] <= d;
        end else begin
          stage_reg[gi] <= stage_reg[(gi == 0) ? 0 : gi-1];
        end
      end
    end
  endgenerate

  assign q = stage_reg[DEPTH-1];

endmodule

// File: rtl/mcu_bus_ctrl.sv
// Slave controller for the MCU-FPGA 8-bit parallel bus. Synchronizes the MCU
// strobes and the pin inputs, decodes the register address, sequences each
// read/write and drives the fpga_ready handshake. Owns the pin output and
// direction registers. The bus/pin tristates live in the level above.
// Optional feature macro: SHADOW_COMMIT_EN (pin writes staged in shadow
// registers, applied together by a write to COMMIT_ADDR).
// Ports:
//  CLK50        in   1           system clock
//  rst          in   1           asynchronous reset, active-high
//  address      in   8           register address, captured in LATCH
//  data_in      in   8           write data, captured in LATCH
//  data_out     out  8           read data to MCU
//  data_oe      out  1           drive data bus with data_out
//  mcu_mstr     in   1           transaction strobe (async)
//  write_enable in   1           1 = write, 0 = read (async)
//  fpga_ready   out  1           transaction acknowledge
//  pin_out      out  PINS_COUNT  pin output values
//  pin_oe       out  PINS_COUNT  pin output enables
//  pin_in       in   PINS_COUNT  raw pin levels (async)
module mcu_bus_ctrl
  import mcu_bus_pkg::*;
#(
  parameter int         PINS_COUNT  = 132,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] ID_VALUE    = 8'hA5
) (
  input  logic                  CLK50,
  input  logic                  rst,
  input  logic [7:0]            address,
  input  logic [7:0]            data_in,
  output logic [7:0]            data_out,
  output logic                  data_oe,
  input  logic                  mcu_mstr,
  input  logic                  write_enable,
  output logic                  fpga_ready,
  output logic [PINS_COUNT-1:0] pin_out,
  output logic [PINS_COUNT-1:0] pin_oe,
  input  logic [PINS_COUNT-1:0] pin_in
);

  localparam int         NB    = num_bytes(PINS_COUNT);
  localparam int         IDX_W = $clog2(NB);
  localparam logic [7:0] NB8   = 8'(NB);

  state_t state_reg, state_next;
  logic [1:0] strb_s;
  logic mstr_s, we_s;
  logic [PINS_COUNT-1:0] pin_in_s;

  logic [7:0] addr_reg, wdata_reg, data_out_reg;
  logic we_reg, addr_err_reg, pending;
  logic [PINS_COUNT-1:0] out_reg, oe_reg, out_view, oe_view, out_wr, oe_wr;
  logic [NB*8-1:0] out_pad, oe_pad, in_pad;
  logic [7:0] out_off, oe_off, in_off, rd_data;
  logic hit_out, hit_oe, hit_in, hit_id, hit_status, hit_commit, acc_err;
  logic exec, wr_out, wr_oe, wr_commit;

  mcu_bus_sync #(.WIDTH(2), .DEPTH(SYNC_STAGES)) u_strb_sync (
    .clk(CLK50), .rst(rst), .d({mcu_mstr, write_enable}), .q(strb_s)
  );
  mcu_bus_sync #(.WIDTH(PINS_COUNT), .DEPTH(SYNC_STAGES)) u_pin_sync (
    .clk(CLK50), .rst(rst), .d(pin_in), .q(pin_in_s)
  );
  assign mstr_s = strb_s[1];
  assign we_s   = strb_s[0];

  // Bank offsets wrap below the base, so a single unsigned compare decodes each bank.
  assign out_off    = addr_reg - OUT_BASE;
  assign oe_off     = addr_reg - OE_BASE;
  assign in_off     = addr_reg - IN_BASE;
  assign hit_out    = out_off < NB8;
  assign hit_oe     = oe_off < NB8;
  assign hit_in     = in_off < NB8;
  assign hit_id     = addr_reg == ID_ADDR;
  assign hit_status = addr_reg == STATUS_ADDR;
`ifdef SHADOW_COMMIT_EN
  assign hit_commit = addr_reg == COMMIT_ADDR;
`else
  assign hit_commit = 1'b0;
`endif
  assign acc_err = ~(hit_out | hit_oe | hit_in | hit_id | hit_status | hit_commit)
                 | (we_reg & (hit_in | hit_id | hit_status));

  assign exec      = state_reg == EXEC;
  assign wr_out    = exec & we_reg & hit_out;
  assign wr_oe     = exec & we_reg & hit_oe;
  assign wr_commit = exec & we_reg & hit_commit;

  genvar gi;
  generate
    // Byte-merge of write data into the selected byte; bits past PINS_COUNT have no storage.
    for (gi = 0; gi < PINS_COUNT; gi++) begin : g_wr
      assign out_wr[gi] = (out_off == 8'(gi / 8)) ? wdata_reg[gi % 8] : out_view[gi];
      assign oe_wr[gi]  = (oe_off  == 8'(gi / 8)) ? wdata_reg[gi % 8] : oe_view[gi];
    end
    // Zero-padded byte views for readback.
    for (gi = 0; gi < NB*8; gi++) begin : g_pad
      if (gi < PINS_COUNT) begin : g_pin
        assign out_pad[gi] = out_view[gi];
        assign oe_pad[gi]  = oe_view[gi];
        assign in_pad[gi]  = pin_in_s[gi];
      end else begin : g_zero
        assign out_pad[gi] = 1'b0;
        assign oe_pad[gi]  = 1'b0;
        assign in_pad[gi]  = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    rd_data = 8'h00;
    if (hit_out)         rd_data = out_pad[{out_off[IDX_W-1:0], 3'b000} +: 8];
    else if (hit_oe)     rd_data = oe_pad[{oe_off[IDX_W-1:0], 3'b000} +: 8];
    else if (hit_in)     rd_data = in_pad[{in_off[IDX_W-1:0], 3'b000} +: 8];
    else if (hit_id)     rd_data = ID_VALUE;
    else if (hit_status) rd_data = {6'b0, pending, addr_err_reg};
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (mstr_s) state_next = LATCH;
      LATCH:   state_next = EXEC;
      EXEC:    state_next = ACK;
      ACK:     if (!mstr_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK50 or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      addr_reg     <= 8'h00;
      wdata_reg    <= 8'h00;
      we_reg       <= 1'b0;
      data_out_reg <= 8'h00;
      addr_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == LATCH) begin
        addr_reg  <= address;
        wdata_reg <= data_in;
        we_reg    <= we_s;
      end
      if (exec) begin
        if (!we_reg) data_out_reg <= rd_data;
        // A fresh error outranks the read-to-clear of STATUS.
        if (acc_err)                     addr_err_reg <= 1'b1;
        else if (!we_reg && hit_status)  addr_err_reg <= 1'b0;
      end
    end
  end

`ifdef SHADOW_COMMIT_EN
  logic [PINS_COUNT-1:0] out_sh_reg, oe_sh_reg;
  logic commit_reg, pending_reg;

  always_ff @(posedge CLK50 or posedge rst) begin
    if (rst) begin
      out_sh_reg  <= '0;
      oe_sh_reg   <= '0;
      out_reg     <= '0;
      oe_reg      <= '0;
      commit_reg  <= 1'b0;
      pending_reg <= 1'b0;
    end else begin
      commit_reg <= wr_commit;
      if (wr_out) out_sh_reg <= out_wr;
      if (wr_oe)  oe_sh_reg  <= oe_wr;
      if (commit_reg) begin
        out_reg <= out_sh_reg;
        oe_reg  <= oe_sh_reg;
      end
      if (wr_out | wr_oe)  pending_reg <= 1'b1;
      else if (commit_reg) pending_reg <= 1'b0;
    end
  end

  assign out_view = out_sh_reg;
  assign oe_view  = oe_sh_reg;
  assign pending  = pending_reg;
`else
  always_ff @(posedge CLK50 or posedge rst) begin
    if (rst) begin
      out_reg <= '0;
      oe_reg  <= '0;
    end else begin
      if (wr_out) out_reg <= out_wr;
      if (wr_oe)  oe_reg  <= oe_wr;
    end
  end

  assign out_view = out_reg;
  assign oe_view  = oe_reg;
  assign pending  = 1'b0;
`endif

  assign pin_out    = out_reg;
  assign pin_oe     = oe_reg;
  assign data_out   = data_out_reg;
  assign fpga_ready = state_reg == ACK;
  assign data_oe    = (state_reg == ACK) & ~we_reg;

endmodule

// File: tb/tb_mcu_bus_ctrl.sv
// Scoreboard bench for mcu_bus_ctrl: a behavioural register model predicts
// read data and pin state; read expectations are queued at drive time and
// popped when fpga_ready rises.
module tb_mcu_bus_ctrl;

  localparam int SYNC = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   address, data_in, data_out;
  logic         data_oe, mcu_mstr, write_enable, fpga_ready;
  logic [131:0] pin_out, pin_oe, pin_in;

  mcu_bus_ctrl #(.PINS_COUNT(132), .SYNC_STAGES(SYNC), .ID_VALUE(8'hA5)) dut (
    .CLK50(clk), .rst(rst), .address(address), .data_in(data_in),
    .data_out(data_out), .data_oe(data_oe), .mcu_mstr(mcu_mstr),
    .write_enable(write_enable), .fpga_ready(fpga_ready),
    .pin_out(pin_out), .pin_oe(pin_oe), .pin_in(pin_in)
  );

  always #10 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  // Register model
  logic [135:0] m_out, m_oe, m_sh_out, m_sh_oe;
  logic         m_err, m_pending;

  task automatic check_eq(input string tag, input logic [135:0] got, input logic [135:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_out = '0; m_oe = '0; m_sh_out = '0; m_sh_oe = '0;
    m_err = 1'b0; m_pending = 1'b0;
  endtask

  function automatic logic [7:0] model_access(input logic [7:0] a, input logic w, input logic [7:0] wd);
    logic [7:0]   r;
    logic [7:0]   msk;
    logic [135:0] in_pad;
    int           k;
    bit           err;
    r = 8'h00; err = 0; in_pad = {4'b0, pin_in};
    if (a <= 8'h10) begin
      k = int'(a); msk = (k == 16) ? 8'h0F : 8'hFF;
      if (w) begin m_sh_out[k*8 +: 8] = wd & msk; m_pending = 1'b1; end
      else r = m_sh_out[k*8 +: 8];
    end else if (a >= 8'h20 && a <= 8'h30) begin
      k = int'(a) - 32; msk = (k == 16) ? 8'h0F : 8'hFF;
      if (w) begin m_sh_oe[k*8 +: 8] = wd & msk; m_pending = 1'b1; end
      else r = m_sh_oe[k*8 +: 8];
    end else if (a >= 8'h40 && a <= 8'h50) begin
      k = int'(a) - 64;
      if (w) err = 1; else r = in_pad[k*8 +: 8];
    end else if (a == 8'hF0) begin
      if (w) err = 1; else r = 8'hA5;
    end else if (a == 8'hF1) begin
      if (w) err = 1;
      else begin r = {6'b0, m_pending, m_err}; m_err = 1'b0; end
`ifdef SHADOW_COMMIT_EN
    end else if (a == 8'hF2) begin
      if (w) begin m_out = m_sh_out; m_oe = m_sh_oe; m_pending = 1'b0; end
`endif
    end else begin
      err = 1;
    end
`ifndef SHADOW_COMMIT_EN
    m_out = m_sh_out; m_oe = m_sh_oe; m_pending = 1'b0;
`endif
    if (err) m_err = 1'b1;
    return r;
  endfunction

  // One full bus transaction; hold = extra clocks to keep mcu_mstr high after fpga_ready.
  task automatic bus_txn(input logic [7:0] a, input logic [7:0] wd, input logic w, input int hold);
    logic [7:0] e;
    int cnt, hi;
    e = model_access(a, w, wd);
    if (!w) exp_q.push_back(e);
    $display("txn addr=%h we=%b wdata=%h expect=%h", a, w, wd, w ? 8'h00 : e);
    @(negedge clk);
    address = a; data_in = wd; write_enable = w; mcu_mstr = 1'b1;
    cnt = 0;
    do begin @(posedge clk); #1; cnt++; end while (!fpga_ready && cnt < 40);
    check_eq("ready_latency", 136'(cnt), 136'(SYNC + 3));
    check_eq("data_oe_ack", 136'(data_oe), 136'(!w));
    if (!w && exp_q.size() > 0) check_eq("rd_data", 136'(data_out), 136'(exp_q.pop_front()));
    if (hold > 0) begin
      hi = 0;
      repeat (hold) begin @(posedge clk); #1; if (fpga_ready) hi++; end
      check_eq("ready_hold", 136'(hi), 136'(hold));
    end
    mcu_mstr = 1'b0;
    cnt = 0;
    do begin @(posedge clk); #1; cnt++; end while (fpga_ready && cnt < 40);
    check_eq("drop_latency", 136'(cnt), 136'(SYNC + 1));
    check_eq("data_oe_idle", 136'(data_oe), 136'd0);
    check_eq("pin_out", {4'b0, pin_out}, m_out);
    check_eq("pin_oe", {4'b0, pin_oe}, m_oe);
  endtask

  logic [7:0] rnd_addrs [16] = '{8'h00, 8'h03, 8'h0F, 8'h10, 8'h11, 8'h20, 8'h2A, 8'h30,
                                 8'h31, 8'h40, 8'h47, 8'h50, 8'h7E, 8'hF0, 8'hF1, 8'hF2};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt_hi;
    logic [7:0] e;
    model_reset();
    rst = 1'b1; address = 8'h00; data_in = 8'h00; mcu_mstr = 1'b0;
    write_enable = 1'b0; pin_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    check_eq("rst_ready", 136'(fpga_ready), 136'd0);
    check_eq("rst_data_oe", 136'(data_oe), 136'd0);
    check_eq("rst_data_out", 136'(data_out), 136'd0);
    check_eq("rst_pin_out", {4'b0, pin_out}, 136'd0);
    check_eq("rst_pin_oe", {4'b0, pin_oe}, 136'd0);

    // Pin byte writes
    bus_txn(8'h03, 8'h5A, 1'b1, 0);
    bus_txn(8'h23, 8'hFF, 1'b1, 0);
`ifdef SHADOW_COMMIT_EN
    bus_txn(8'hF2, 8'h00, 1'b1, 0);
`endif
    check_eq("pin_out_b3", 136'(pin_out[31:24]), 136'h5A);
    check_eq("pin_oe_b3", 136'(pin_oe[31:24]), 136'hFF);

    // Partial top byte and synced input readback
    for (int i = 0; i < 4; i++) pin_in[i*32 +: 32] = $urandom;
    pin_in[131:128] = 4'b1010;
    repeat (4) @(posedge clk);
    bus_txn(8'h50, 8'h00, 1'b0, 0);
    bus_txn(8'h40, 8'h00, 1'b0, 0);
    bus_txn(8'h10, 8'hFF, 1'b1, 0);
`ifdef SHADOW_COMMIT_EN
    bus_txn(8'hF2, 8'h00, 1'b1, 0);
`endif
    check_eq("pin_out_top", 136'(pin_out[131:128]), 136'hF);
    bus_txn(8'h10, 8'h00, 1'b0, 0);

    // Errors, STATUS read-to-clear, ID
    bus_txn(8'h7E, 8'h00, 1'b0, 0);
    bus_txn(8'hF1, 8'h00, 1'b0, 0);
    bus_txn(8'hF1, 8'h00, 1'b0, 0);
    bus_txn(8'hF0, 8'h00, 1'b0, 0);
    bus_txn(8'hF0, 8'h3C, 1'b1, 0);
    bus_txn(8'h45, 8'h3C, 1'b1, 0);
    bus_txn(8'hF1, 8'h00, 1'b0, 0);
    bus_txn(8'hF1, 8'h00, 1'b0, 0);

    // Long handshake
    bus_txn(8'hF0, 8'h00, 1'b0, 20);

    // Strobe dropped while in LATCH: transaction still completes, ready pulses once
    e = model_access(8'h05, 1'b1, 8'hC3);
    $display("txn addr=05 we=1 wdata=c3 early strobe drop");
    @(negedge clk);
    address = 8'h05; data_in = 8'hC3; write_enable = 1'b1; mcu_mstr = 1'b1;
    repeat (3) @(posedge clk);
    #1 mcu_mstr = 1'b0;
    cnt_hi = 0;
    repeat (10) begin @(posedge clk); #1; if (fpga_ready) cnt_hi++; end
    check_eq("early_drop_pulse", 136'(cnt_hi), 136'd1);
    check_eq("early_drop_pin", {4'b0, pin_out}, m_out);

`ifdef SHADOW_COMMIT_EN
    bus_txn(8'hF2, 8'h00, 1'b1, 0);
    bus_txn(8'hF1, 8'h00, 1'b0, 0);
    bus_txn(8'h00, 8'h33, 1'b1, 0);
    check_eq("shadow_hold", 136'(pin_out[7:0]), 136'h00);
    bus_txn(8'hF1, 8'h00, 1'b0, 0);
    bus_txn(8'hF2, 8'h00, 1'b1, 0);
    check_eq("shadow_commit", 136'(pin_out[7:0]), 136'h33);
`endif

    // Mixed random traffic
    for (int n = 0; n < 24; n++) begin
      bus_txn(rnd_addrs[$urandom_range(0, 15)], 8'($urandom), 1'($urandom), 0);
    end

    // Reset during ACK of a read
    e = model_access(8'h23, 1'b0, 8'h00);
    exp_q.push_back(e);
    $display("txn addr=23 we=0 expect=%h reset in ACK", e);
    @(negedge clk);
    address = 8'h23; write_enable = 1'b0; mcu_mstr = 1'b1;
    cnt_hi = 0;
    do begin @(posedge clk); #1; cnt_hi++; end while (!fpga_ready && cnt_hi < 40);
    check_eq("rstack_ready", 136'(fpga_ready), 136'd1);
    check_eq("rstack_data_oe", 136'(data_oe), 136'd1);
    check_eq("rstack_data", 136'(data_out), 136'(exp_q.pop_front()));
    #3 rst = 1'b1;
    #1;
    check_eq("arst_ready", 136'(fpga_ready), 136'd0);
    check_eq("arst_data_oe", 136'(data_oe), 136'd0);
    check_eq("arst_pin_oe", {4'b0, pin_oe}, 136'd0);
    check_eq("arst_pin_out", {4'b0, pin_out}, 136'd0);
    model_reset();
    mcu_mstr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_eq("post_rst_idle", 136'(fpga_ready), 136'd0);
    bus_txn(8'hF1, 8'h00, 1'b0, 0);
    bus_txn(8'h2A, 8'h81, 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
